// File: rtl/traffic_controller_nway.sv
// traffic_controller_nway
// N-direction signalised junction controller. Requests are latched and served
// round-robin; every change of right-of-way runs GREEN -> YELLOW -> ALL_RED.
// Phase lengths are counted in prescaled ticks. Green has a minimum and a
// maximum length, and an emergency input can pre-empt or hold the green.
module traffic_controller_nway #(
    parameter int N_DIR        = 4,
    parameter int TICK_DIV     = 10_000_000,
    parameter int GREEN_TICKS  = 30,
    parameter int MIN_GREEN    = 10,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 1,
    localparam int DIR_W       = $clog2(N_DIR)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_DIR-1:0] req,
    input  logic             emerg_vld,
    input  logic [DIR_W-1:0] emerg_dir,
    output logic [N_DIR-1:0] red,
    output logic [N_DIR-1:0] yellow,
    output logic [N_DIR-1:0] green,
    output logic [DIR_W-1:0] active_dir,
    output logic [1:0]       phase,
    output logic [N_DIR-1:0] pending
);

    localparam int MAX_A     = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
    localparam int MAX_TICKS = (MAX_A > ALLRED_TICKS) ? MAX_A : ALLRED_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);
    localparam int PRE_W     = $clog2(TICK_DIV + 1);

    localparam logic [DIR_W:0]   NDIR_C    = (DIR_W+1)'(N_DIR);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_TICKS);
    localparam logic [CNT_W-1:0] CNT_GREEN = CNT_W'(GREEN_TICKS);
    localparam logic [CNT_W-1:0] CNT_MIN   = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] CNT_YEL   = CNT_W'(YELLOW_TICKS);
    localparam logic [CNT_W-1:0] CNT_AR    = CNT_W'(ALLRED_TICKS);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'b00,
        ST_GREEN   = 2'b01,
        ST_YELLOW  = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PRE_W-1:0]   r_presc;
    logic [CNT_W-1:0]   r_ph_cnt;
    logic [DIR_W-1:0]   r_active;
    logic [N_DIR-1:0]   r_pending;

    logic               w_tick;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_emerg_ok;
    logic               w_hold;
    logic               w_preempt;
    logic               w_others;
    logic               w_max_green;
    logic               w_early_green;
    logic               w_enter_green;
    logic               w_state_chg;
    logic [N_DIR-1:0]   w_active_oh;
    logic [N_DIR-1:0]   w_clr_mask;
    logic [DIR_W-1:0]   w_scan_dir;
    logic               w_scan_hit;
    logic [DIR_W-1:0]   w_scan_idx;
    logic [DIR_W-1:0]   w_next_dir;

    // Tick strobe and the tick count the phase counter will hold after this
    // cycle; the counter saturates so a held green never wraps.
    always_comb begin
        w_tick    = (r_presc == PRE_LAST);
        w_cnt_nxt = r_ph_cnt;
        if (w_tick && (r_ph_cnt != CNT_MAX)) begin
            w_cnt_nxt = r_ph_cnt + CNT_W'(1);
        end
    end

    // Emergency qualification and green termination rules.
    always_comb begin
        w_active_oh   = N_DIR'(1) << r_active;
        w_emerg_ok    = emerg_vld && ({1'b0, emerg_dir} < NDIR_C);
        w_hold        = w_emerg_ok && (emerg_dir == r_active);
        w_preempt     = w_emerg_ok && (emerg_dir != r_active);
        w_others      = |(r_pending & ~w_active_oh);
        w_max_green   = !w_hold && (w_cnt_nxt >= CNT_GREEN);
        w_early_green = !w_hold && (w_cnt_nxt >= CNT_MIN) && w_others && !req[r_active];
    end

    // Round-robin scan: first pending direction after the active one, else
    // simply the next direction so the junction keeps rotating when idle.
    always_comb begin
        w_scan_dir = DIR_W'((int'(r_active) + 1) % N_DIR);
        w_scan_hit = 1'b0;
        w_scan_idx = '0;
        for (int k = 1; k <= N_DIR; k++) begin
            w_scan_idx = DIR_W'((int'(r_active) + k) % N_DIR);
            if (!w_scan_hit && r_pending[w_scan_idx]) begin
                w_scan_hit = 1'b1;
                w_scan_dir = w_scan_idx;
            end
        end
        w_next_dir = w_emerg_ok ? emerg_dir : w_scan_dir;
    end

    // Next-state logic; a valid emergency for another direction cuts green
    // short immediately, but yellow and all-red always run their full length.
    always_comb begin
        w_state_nxt   = r_state;
        w_enter_green = 1'b0;
        case (r_state)
            ST_ALL_RED: begin
                if (w_cnt_nxt >= CNT_AR) begin
                    w_state_nxt   = ST_GREEN;
                    w_enter_green = 1'b1;
                end
            end
            ST_GREEN: begin
                if (w_preempt || w_max_green || w_early_green) begin
                    w_state_nxt = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (w_cnt_nxt >= CNT_YEL) begin
                    w_state_nxt = ST_ALL_RED;
                end
            end
            default: begin
                w_state_nxt = ST_ALL_RED;
            end
        endcase
        w_state_chg = (w_state_nxt != r_state);
        w_clr_mask  = w_enter_green ? (N_DIR'(1) << w_next_dir) : '0;
    end

    // Phase state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ALL_RED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Prescaler and phase tick counter, both restarted when a phase is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc  <= '0;
            r_ph_cnt <= '0;
        end else if (w_state_chg) begin
            r_presc  <= '0;
            r_ph_cnt <= '0;
        end else begin
            r_presc  <= w_tick ? '0 : (r_presc + PRE_W'(1));
            r_ph_cnt <= w_cnt_nxt;
        end
    end

    // Active direction is loaded when leaving all-red into green.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= DIR_W'(N_DIR - 1);
        end else if (w_enter_green) begin
            r_active <= w_next_dir;
        end
    end

    // Request latch; the direction being granted is cleared, overriding a
    // simultaneous request from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending | req) & ~w_clr_mask;
        end
    end

    // Lamp decode: the active direction shows green or yellow, all else red.
    always_comb begin
        green      = (r_state == ST_GREEN)  ? w_active_oh : '0;
        yellow     = (r_state == ST_YELLOW) ? w_active_oh : '0;
        red        = ~(green | yellow);
        active_dir = r_active;
        phase      = r_state;
        pending    = r_pending;
    end

endmodule

// File: tb/tb_traffic_controller_nway.sv
// Testbench for traffic_controller_nway: directed scenarios plus randomized
// traffic checked against a cycle-count based reference model.
module tb_traffic_controller_nway;

    localparam int N  = 4;
    localparam int TD = 2;
    localparam int GT = 4;
    localparam int MG = 2;
    localparam int YT = 2;
    localparam int AT = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req = '0;
    logic       emerg_vld = 1'b0;
    logic [1:0] emerg_dir = '0;
    logic [3:0] red, yellow, green, pending;
    logic [1:0] active_dir, phase;

    logic [4:0] req5 = '0;
    logic       ev5 = 1'b1;
    logic [2:0] ed5 = 3'd5;
    logic [4:0] red5, yellow5, green5, pend5;
    logic [2:0] ad5;
    logic [1:0] ph5;

    int errors = 0;
    int checks = 0;

    // Reference model state: phase (0 all-red, 1 green, 2 yellow), owner,
    // latched requests and clock cycles spent in the current phase.
    int         m_ph;
    int         m_dir;
    int         m_el;
    logic [3:0] m_pend;

    traffic_controller_nway #(
        .N_DIR(N), .TICK_DIV(TD), .GREEN_TICKS(GT), .MIN_GREEN(MG),
        .YELLOW_TICKS(YT), .ALLRED_TICKS(AT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .emerg_vld(emerg_vld),
        .emerg_dir(emerg_dir), .red(red), .yellow(yellow), .green(green),
        .active_dir(active_dir), .phase(phase), .pending(pending)
    );

    traffic_controller_nway #(
        .N_DIR(5), .TICK_DIV(TD), .GREEN_TICKS(GT), .MIN_GREEN(MG),
        .YELLOW_TICKS(YT), .ALLRED_TICKS(AT)
    ) dut5 (
        .clk(clk), .rst_n(rst_n), .req(req5), .emerg_vld(ev5),
        .emerg_dir(ed5), .red(red5), .yellow(yellow5), .green(green5),
        .active_dir(ad5), .phase(ph5), .pending(pend5)
    );

    always #5 clk = ~clk;

    // Lamp sanity on both instances: one lamp per direction, green one-hot-or-zero.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert (((red ^ yellow ^ green) == 4'hF) && (((red & yellow) | (red & green) | (yellow & green)) == 4'h0)
                    && $onehot0(green))
            else begin
                errors++;
                $display("FAIL lamps4 r=%b y=%b g=%b", red, yellow, green);
            end
            checks++;
            assert (((red5 ^ yellow5 ^ green5) == 5'h1F) && (((red5 & yellow5) | (red5 & green5) | (yellow5 & green5)) == 5'h0)
                    && $onehot0(green5))
            else begin
                errors++;
                $display("FAIL lamps5 r=%b y=%b g=%b", red5, yellow5, green5);
            end
        end
    end

    task automatic model_reset();
        m_ph = 0; m_dir = N - 1; m_el = 0; m_pend = '0;
    endtask

    task automatic model_step();
        int ta; bit done; bit hold; bit others; int nd;
        logic [3:0] np; logic [1:0] ix;
        ta = (m_el + 1) / TD;
        done = 1'b0;
        np = m_pend | req;
        case (m_ph)
            0: if (ta >= AT) begin
                if (emerg_vld) nd = int'(emerg_dir);
                else begin
                    nd = (m_dir + 1) % N;
                    for (int k = N; k >= 1; k--) begin
                        ix = 2'((m_dir + k) % N);
                        if (m_pend[ix]) nd = int'(ix);
                    end
                end
                m_dir = nd;
                np[2'(nd)] = 1'b0;
                m_ph = 1; done = 1'b1;
            end
            1: begin
                hold   = emerg_vld && (int'(emerg_dir) == m_dir);
                others = (m_pend & ~(4'b0001 << m_dir)) != 4'b0;
                if ((emerg_vld && !hold) || (!hold && ta >= GT) ||
                    (!hold && ta >= MG && others && !req[2'(m_dir)])) begin
                    m_ph = 2; done = 1'b1;
                end
            end
            default: if (ta >= YT) begin m_ph = 0; done = 1'b1; end
        endcase
        m_pend = np;
        m_el = done ? 0 : m_el + 1;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask

    // Length in samples of the current phase/owner, leaving the bench on the
    // first sample of the following phase.
    task automatic run_len(output int len, output logic [1:0] ph, output logic [1:0] dir);
        ph = phase; dir = active_dir; len = 1;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (phase !== ph || active_dir !== dir) break;
            len++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({red, yellow, green, active_dir, phase, pending} !== {4'hF, 4'h0, 4'h0, 2'd3, 2'd0, 4'h0}) begin
            errors++;
            $display("FAIL reset_async got r=%h y=%h g=%h ad=%0d ph=%0d pd=%h want r=F y=0 g=0 ad=3 ph=0 pd=0",
                     red, yellow, green, active_dir, phase, pending);
        end
        req = 4'hF;
        repeat (3) cyc();
        checks++;
        if ({red, active_dir, phase, pending} !== {4'hF, 2'd3, 2'd0, 4'h0}) begin
            errors++;
            $display("FAIL reset_hold got r=%h ad=%0d ph=%0d pd=%h want r=F ad=3 ph=0 pd=0",
                     red, active_dir, phase, pending);
        end
        req = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        int len; logic [1:0] ph, dir;
        int exp_len[4] = '{2, 8, 4, 2};
        int exp_ph[4]  = '{0, 1, 2, 0};
        int exp_dir[4] = '{3, 0, 0, 0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_len(len, ph, dir);
            checks++;
            if (len != exp_len[i] || int'(ph) != exp_ph[i] || int'(dir) != exp_dir[i]) begin
                errors++;
                $display("FAIL idle_seq%0d got len=%0d ph=%0d dir=%0d want len=%0d ph=%0d dir=%0d",
                         i, len, ph, dir, exp_len[i], exp_ph[i], exp_dir[i]);
            end
        end
        checks++;
        if (green !== 4'b0010) begin
            errors++;
            $display("FAIL idle_next got green=%b want 0010", green);
        end
    endtask

    task automatic test_skip();
        int len; logic [1:0] ph, dir;
        do_reset();
        run_len(len, ph, dir);
        cyc();
        req = 4'b0100;
        cyc();
        req = 4'b0000;
        checks++;
        if (pending !== 4'b0100) begin
            errors++;
            $display("FAIL skip_pending got %b want 0100", pending);
        end
        run_len(len, ph, dir);
        checks++;
        if (len != 2 || ph !== 2'd1 || dir !== 2'd0) begin
            errors++;
            $display("FAIL skip_mingreen got rest_len=%0d ph=%0d dir=%0d want 2 1 0", len, ph, dir);
        end
        run_len(len, ph, dir);
        run_len(len, ph, dir);
        checks++;
        if (green !== 4'b0100 || pending !== 4'b0000) begin
            errors++;
            $display("FAIL skip_next got green=%b pending=%b want 0100 0000", green, pending);
        end
    endtask

    task automatic test_hold_req();
        int len; logic [1:0] ph, dir;
        do_reset();
        run_len(len, ph, dir);
        req = 4'b1001;
        cyc();
        req = 4'b0001;
        run_len(len, ph, dir);
        checks++;
        if (len != 7 || ph !== 2'd1 || dir !== 2'd0) begin
            errors++;
            $display("FAIL hold_fullgreen got rest_len=%0d ph=%0d dir=%0d want 7 1 0", len, ph, dir);
        end
        run_len(len, ph, dir);
        run_len(len, ph, dir);
        req = 4'b0000;
        checks++;
        if (green !== 4'b1000) begin
            errors++;
            $display("FAIL hold_next got green=%b want 1000", green);
        end
    endtask

    task automatic test_emerg();
        int len; int bad; logic [1:0] ph, dir;
        do_reset();
        run_len(len, ph, dir);
        cyc();
        emerg_vld = 1'b1;
        emerg_dir = 2'd3;
        cyc();
        checks++;
        if (yellow !== 4'b0001) begin
            errors++;
            $display("FAIL emerg_preempt got yellow=%b want 0001", yellow);
        end
        run_len(len, ph, dir);
        checks++;
        if (len != 4 || ph !== 2'd2) begin
            errors++;
            $display("FAIL emerg_yellow got len=%0d ph=%0d want 4 2", len, ph);
        end
        run_len(len, ph, dir);
        checks++;
        if (len != 2 || ph !== 2'd0) begin
            errors++;
            $display("FAIL emerg_allred got len=%0d ph=%0d want 2 0", len, ph);
        end
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            if (green !== 4'b1000) bad++;
            cyc();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL emerg_hold got %0d cycles without green[3] want 0", bad);
        end
        emerg_vld = 1'b0;
        run_len(len, ph, dir);
        checks++;
        if (len != 1 || yellow !== 4'b1000) begin
            errors++;
            $display("FAIL emerg_release got len=%0d yellow=%b want 1 1000", len, yellow);
        end
    endtask

    task automatic test_emerg_invalid();
        int eph, ead, k, r, bad;
        logic [4:0] eg;
        ev5 = 1'b1;
        bad = 0;
        do_reset();
        for (int s = 0; s < 86; s++) begin
            ed5 = (s % 3 == 0) ? 3'd7 : 3'd5;
            if (s < 2) begin
                eph = 0; ead = 4;
            end else begin
                k = (s - 2) / 14; r = (s - 2) % 14;
                ead = k % 5;
                eph = (r < 8) ? 1 : ((r < 12) ? 2 : 0);
            end
            eg = (eph == 1) ? 5'(1 << ead) : 5'b0;
            checks++;
            if ({ph5, ad5, green5} !== {2'(eph), 3'(ead), eg}) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL emerg_invalid s=%0d got ph=%0d ad=%0d g=%b want ph=%0d ad=%0d g=%b",
                             s, ph5, ad5, green5, eph, ead, eg);
            end
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        int len; logic [1:0] ph, dir;
        do_reset();
        run_len(len, ph, dir);
        req = 4'b0110;
        cyc();
        req = 4'b0000;
        run_len(len, ph, dir);
        cyc();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({red, active_dir, pending, phase} !== {4'hF, 2'd3, 4'h0, 2'd0}) begin
            errors++;
            $display("FAIL reset_mid got r=%h ad=%0d pd=%h ph=%0d want F 3 0 0", red, active_dir, pending, phase);
        end
        cyc();
        rst_n = 1'b1;
        run_len(len, ph, dir);
        checks++;
        if (len != 2 || ph !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_ar got len=%0d ph=%0d want 2 0", len, ph);
        end
        run_len(len, ph, dir);
        checks++;
        if (len != 8 || ph !== 2'd1 || dir !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_green got len=%0d ph=%0d dir=%0d want 8 1 0", len, ph, dir);
        end
    endtask

    task automatic test_random();
        logic [3:0] eg, ey, er;
        int bad;
        bad = 0;
        emerg_vld = 1'b0;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 4; b++) req[b] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 59) == 0) begin
                emerg_vld = ~emerg_vld;
                emerg_dir = 2'($urandom_range(0, 3));
            end else if ($urandom_range(0, 199) == 0) begin
                emerg_dir = 2'($urandom_range(0, 3));
            end
            cyc();
            eg = (m_ph == 1) ? 4'(1 << m_dir) : 4'b0;
            ey = (m_ph == 2) ? 4'(1 << m_dir) : 4'b0;
            er = ~(eg | ey);
            checks++;
            if ({red, yellow, green, active_dir, phase, pending} !== {er, ey, eg, 2'(m_dir), 2'(m_ph), m_pend}) begin
                errors++;
                bad++;
                if (bad < 6)
                    $display("FAIL random c=%0d got r=%b y=%b g=%b ad=%0d ph=%0d pd=%b want r=%b y=%b g=%b ad=%0d ph=%0d pd=%b",
                             c, red, yellow, green, active_dir, phase, pending, er, ey, eg, m_dir, m_ph, m_pend);
            end
        end
        req = '0;
        emerg_vld = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_idle();
        test_skip();
        test_hold_req();
        test_emerg();
        test_emerg_invalid();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
